// File: rtl/rtc_display_scanner.sv
// Time-multiplexed scanner for an 8-digit 7-segment display: one digit lit at a time,
// with a blanking gap between digits and inputs captured once per frame.
module rtc_display_scanner #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_digit_enable,
  input  logic [NUM_DIGITS-1:0]   i_dp_mask,
  input  logic                    i_lz_suppress,
  output logic [3:0]              o_bcd_digit,
  output logic [NUM_DIGITS-1:0]   o_anode,
  output logic                    o_dp,
  output logic                    o_frame_start
);

  localparam int unsigned MaxCycles = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles);
  localparam int unsigned IdxW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(DIGIT_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;

  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    snap_lz_q, snap_lz_d;

  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [3:0]              bcd_q, bcd_d;
  logic                    dp_q, dp_d;
  logic                    fs_q, fs_d;

  // Digit 0 is lit on the same edge that captures the snapshot, so it reads the live inputs.
  logic                    use_live;
  logic [4*NUM_DIGITS-1:0] eff_digits;
  logic [NUM_DIGITS-1:0]   eff_en;
  logic [NUM_DIGITS-1:0]   eff_dp;
  logic                    eff_lz;

  assign use_live   = (idx_q == '0);
  assign eff_digits = use_live ? i_digits       : snap_digits_q;
  assign eff_en     = use_live ? i_digit_enable : snap_en_q;
  assign eff_dp     = use_live ? i_dp_mask      : snap_dp_q;
  assign eff_lz     = use_live ? i_lz_suppress  : snap_lz_q;

  logic [3:0]            digit_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] zero_from;
  logic                  zero_run;

  // zero_from[k]: digit k and every digit above it are zero (enable is ignored here).
  always_comb begin
    zero_run  = 1'b1;
    zero_from = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      digit_arr[k] = eff_digits[4*k +: 4];
      zero_run     = zero_run & (eff_digits[4*k +: 4] == 4'h0);
      zero_from[k] = zero_run;
    end
  end

  logic [3:0]            cur_digit;
  logic                  cur_en;
  logic                  cur_dp;
  logic                  cur_sup;
  logic [NUM_DIGITS-1:0] anode_sel;

  assign cur_digit = digit_arr[idx_q];
  assign cur_en    = eff_en[idx_q];
  assign cur_dp    = eff_dp[idx_q];
  assign cur_sup   = eff_lz && (idx_q != '0) && zero_from[idx_q];
  assign anode_sel = ~(NUM_DIGITS'(1) << idx_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CntW'(1);
    idx_d         = idx_q;
    snap_digits_d = snap_digits_q;
    snap_en_d     = snap_en_q;
    snap_dp_d     = snap_dp_q;
    snap_lz_d     = snap_lz_q;
    anode_d       = anode_q;
    bcd_d         = bcd_q;
    dp_d          = dp_q;
    fs_d          = 1'b0;

    unique case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StShow;
          cnt_d   = '0;
          fs_d    = use_live;
          if (use_live) begin
            snap_digits_d = i_digits;
            snap_en_d     = i_digit_enable;
            snap_dp_d     = i_dp_mask;
            snap_lz_d     = i_lz_suppress;
          end
          anode_d = '1;
          bcd_d   = 4'hF;
          dp_d    = 1'b1;
          if (cur_en) begin
            if (cur_sup) begin
              // A suppressed zero still shows its decimal point, if requested.
              if (cur_dp) begin
                anode_d = anode_sel;
                dp_d    = 1'b0;
              end
            end else begin
              anode_d = anode_sel;
              bcd_d   = cur_digit;
              dp_d    = ~cur_dp;
            end
          end
        end
      end
      StShow: begin
        if (cnt_q == ShowLast) begin
          state_d = StBlank;
          cnt_d   = '0;
          idx_d   = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
          anode_d = '1;
          bcd_d   = 4'hF;
          dp_d    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= StBlank;
      cnt_q         <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_en_q     <= '0;
      snap_dp_q     <= '0;
      snap_lz_q     <= 1'b0;
      anode_q       <= '1;
      bcd_q         <= 4'hF;
      dp_q          <= 1'b1;
      fs_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_en_q     <= snap_en_d;
      snap_dp_q     <= snap_dp_d;
      snap_lz_q     <= snap_lz_d;
      anode_q       <= anode_d;
      bcd_q         <= bcd_d;
      dp_q          <= dp_d;
      fs_q          <= fs_d;
    end
  end

  assign o_anode       = anode_q;
  assign o_bcd_digit   = bcd_q;
  assign o_dp          = dp_q;
  assign o_frame_start = fs_q;

endmodule

// File: tb/tb_rtc_display_scanner.sv
// Directed bench for rtc_display_scanner: expected per-cycle outputs are queued per frame
// and compared cycle by cycle on the falling edge.
module tb_rtc_display_scanner;

  localparam int unsigned ND = 8;
  localparam int unsigned DC = 4;
  localparam int unsigned BC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] digits;
  logic [7:0]  en;
  logic [7:0]  dpm;
  logic        lz;
  logic [3:0]  bcd;
  logic [7:0]  anode;
  logic        dp;
  logic        fs;

  always #5 clk = ~clk;

  rtc_display_scanner #(
    .NUM_DIGITS  (ND),
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_digits      (digits),
    .i_digit_enable(en),
    .i_dp_mask     (dpm),
    .i_lz_suppress (lz),
    .o_bcd_digit   (bcd),
    .o_anode       (anode),
    .o_dp          (dp),
    .o_frame_start (fs)
  );

  typedef struct packed {
    logic [7:0] anode;
    logic [3:0] bcd;
    logic       dp;
    logic       fs;
  } obs_t;

  obs_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  string phase  = "init";

  // Expected lit-phase outputs for position k, from the highest nonzero digit.
  function automatic obs_t expect_pos(input logic [31:0] d, input logic [7:0] e,
                                      input logic [7:0] m, input logic z, input int k,
                                      input logic f);
    obs_t       r;
    int         hi;
    logic [7:0] one;
    one = 8'h01;
    hi  = -1;
    for (int j = 0; j < int'(ND); j++) if (d[4*j +: 4] != 4'h0) hi = j;
    r.anode = 8'hFF;
    r.bcd   = 4'hF;
    r.dp    = 1'b1;
    r.fs    = f;
    if (e[k]) begin
      if (z && k > 0 && k > hi) begin
        if (m[k]) begin
          r.anode = ~(one << k);
          r.dp    = 1'b0;
        end
      end else begin
        r.anode = ~(one << k);
        r.bcd   = d[4*k +: 4];
        r.dp    = ~m[k];
      end
    end
    return r;
  endfunction

  task automatic push_blank();
    obs_t r;
    r.anode = 8'hFF;
    r.bcd   = 4'hF;
    r.dp    = 1'b1;
    r.fs    = 1'b0;
    exp_q.push_back(r);
  endtask

  task automatic push_frame(input logic [31:0] d, input logic [7:0] e, input logic [7:0] m,
                            input logic z);
    for (int k = 0; k < int'(ND); k++) begin
      for (int b = 0; b < int'(BC); b++) push_blank();
      for (int c = 0; c < int'(DC); c++) exp_q.push_back(expect_pos(d, e, m, z, k, k == 0 && c == 0));
    end
  endtask

  task automatic check_now();
    obs_t o;
    obs_t x;
    o.anode = anode;
    o.bcd   = bcd;
    o.dp    = dp;
    o.fs    = fs;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s cycle %0d: no expected entry queued, observed anode=%h bcd=%h dp=%b fs=%b",
             phase, cyc, o.anode, o.bcd, o.dp, o.fs);
    end else begin
      x = exp_q.pop_front();
      assert (o === x) else begin
        errors++;
        $error("FAIL %s cycle %0d: observed anode=%h bcd=%h dp=%b fs=%b, expected anode=%h bcd=%h dp=%b fs=%b",
               phase, cyc, o.anode, o.bcd, o.dp, o.fs, x.anode, x.bcd, x.dp, x.fs);
      end
    end
    cyc++;
  endtask

  task automatic check_cycles(input int n);
    repeat (n) begin
      check_now();
      @(negedge clk);
    end
  endtask

  initial begin
    rst    = 1'b1;
    digits = 32'h12345678;
    en     = 8'hFF;
    dpm    = 8'h00;
    lz     = 1'b0;

    // Reset values while the clock runs.
    phase = "reset";
    repeat (3) @(negedge clk);
    push_blank();
    check_now();

    // First frames after release, then a repeat to see frame_start every 48 cycles.
    rst   = 1'b0;
    phase = "scan";
    cyc   = 0;
    push_frame(32'h12345678, 8'hFF, 8'h00, 1'b0);
    check_cycles(48);
    push_frame(32'h12345678, 8'hFF, 8'h00, 1'b0);
    check_cycles(48);

    // Input change while digit 3 is lit must not tear the current frame.
    phase = "torn";
    cyc   = 0;
    push_frame(32'h12345678, 8'hFF, 8'h00, 1'b0);
    check_cycles(21);
    digits = 32'h87654321;
    check_cycles(27);
    push_frame(32'h87654321, 8'hFF, 8'h00, 1'b0);
    check_cycles(48);

    // Leading-zero suppression.
    phase  = "lz305";
    cyc    = 0;
    digits = 32'h00000305;
    lz     = 1'b1;
    push_frame(digits, en, dpm, lz);
    check_cycles(48);
    phase  = "lz0";
    cyc    = 0;
    digits = 32'h00000000;
    push_frame(digits, en, dpm, lz);
    check_cycles(48);

    // Decimal point on a suppressed zero, then the same position disabled.
    phase  = "lzdp";
    cyc    = 0;
    digits = 32'h00001234;
    dpm    = 8'h10;
    push_frame(digits, en, dpm, lz);
    check_cycles(48);
    phase  = "lzdis";
    cyc    = 0;
    en     = 8'h0F;
    push_frame(digits, en, dpm, lz);
    check_cycles(48);

    // Asynchronous reset in the middle of position 5's lit phase.
    phase  = "midrst";
    cyc    = 0;
    en     = 8'hFF;
    dpm    = 8'h00;
    lz     = 1'b0;
    digits = 32'h12345678;
    push_frame(digits, en, dpm, lz);
    check_cycles(33);
    exp_q.delete();
    #1 rst = 1'b1;
    #1;
    push_blank();
    check_now();
    @(negedge clk);
    push_blank();
    check_now();
    @(negedge clk);
    rst   = 1'b0;
    phase = "postrst";
    cyc   = 0;
    push_frame(digits, en, dpm, lz);
    check_cycles(48);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
